// File: rtl/mp32_store_unit_if.sv
// Store-unit bus: MEM-stage store request on one side, data-memory write port on the other.
interface mp32_store_unit_if;
    logic        MemWrite;
    logic [1:0]  StoreSize;
    logic [31:0] Addr;
    logic [31:0] WDataIn;
    logic        mem_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        Stall;
    logic        Done;
    logic        AddrErr;
    logic        BusErr;

    modport master (
        output MemWrite, StoreSize, Addr, WDataIn, mem_ack,
        input  mem_req, mem_addr, mem_wdata, mem_be, Stall, Done, AddrErr, BusErr
    );

    modport slave (
        input  MemWrite, StoreSize, Addr, WDataIn, mem_ack,
        output mem_req, mem_addr, mem_wdata, mem_be, Stall, Done, AddrErr, BusErr
    );
endinterface

// File: rtl/mp32_store_unit.sv
// MP32 store unit: alignment check, byte-lane steering and a timed write handshake
// to data memory, stalling the pipeline while a store is outstanding.
module mp32_store_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    mp32_store_unit_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, REQ, ERR} state_t;

    localparam logic [3:0] LP_LAST = 4'(TIMEOUT - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_be;
    logic        r_done;
    logic        r_addr_err;
    logic        r_bus_err;

    logic        w_aligned;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;

    // Lane steering: narrow stores are replicated across the word so memory picks by be.
    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b0000;
        w_wdata   = bus.WDataIn;
        case (bus.StoreSize)
            2'b00: begin
                w_aligned = (bus.Addr[1:0] == 2'b00);
                w_be      = 4'b1111;
                w_wdata   = bus.WDataIn;
            end
            2'b01: begin
                w_aligned = ~bus.Addr[0];
                w_be      = bus.Addr[1] ? 4'b1100 : 4'b0011;
                w_wdata   = {2{bus.WDataIn[15:0]}};
            end
            2'b10: begin
                w_aligned = 1'b1;
                w_be      = 4'b0001 << bus.Addr[1:0];
                w_wdata   = {4{bus.WDataIn[7:0]}};
            end
            default: begin
                w_aligned = 1'b0;
                w_be      = 4'b0000;
                w_wdata   = bus.WDataIn;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'b0000;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
            r_bus_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.MemWrite) begin
                        if (w_aligned) begin
                            r_mem_addr  <= {bus.Addr[31:2], 2'b00};
                            r_mem_wdata <= w_wdata;
                            r_mem_be    <= w_be;
                            r_mem_req   <= 1'b1;
                            r_cnt       <= 4'd0;
                            r_state     <= REQ;
                        end else begin
                            r_addr_err <= 1'b1;
                            r_state    <= ERR;
                        end
                    end
                end
                REQ: begin
                    // Ack is checked first so an ack on the last allowed cycle still completes.
                    if (bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_mem_be  <= 4'b0000;
                        r_done    <= 1'b1;
                        r_state   <= IDLE;
                    end else if (r_cnt == LP_LAST) begin
                        r_mem_req <= 1'b0;
                        r_mem_be  <= 4'b0000;
                        r_bus_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ERR: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;
    assign bus.Done      = r_done;
    assign bus.AddrErr   = r_addr_err;
    assign bus.BusErr    = r_bus_err;
    assign bus.Stall     = (r_state == REQ) || ((r_state == IDLE) && bus.MemWrite && w_aligned);

endmodule

// File: tb/tb_mp32_store_unit.sv
// Scoreboard bench for mp32_store_unit: each store pushes its expected outcome,
// a negedge monitor pops and compares when Done/AddrErr/BusErr fires.
module tb_mp32_store_unit;

    localparam int TIMEOUT = 15;
    localparam int K_DONE  = 0;
    localparam int K_AERR  = 1;
    localparam int K_BERR  = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    logic clk;
    logic reset_n;
    mp32_store_unit_if bus ();

    mp32_store_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_req = 1'b0;
    logic [31:0] cap_addr = 32'd0;
    logic [31:0] cap_wdata = 32'd0;
    logic [3:0]  cap_be = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference lane model: lane k enabled inside [off, off+nbytes), carries source byte k mod nbytes.
    function automatic void model(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                                  output logic ok, output logic [3:0] be, output logic [31:0] wd);
        int nb;
        int off;
        nb  = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
        off = int'(a[1:0]);
        ok  = (sz != 2'b11) && ((off % nb) == 0);
        be  = 4'b0000;
        wd  = 32'd0;
        if (ok) begin
            for (int k = 0; k < 4; k++) begin
                if (k >= off && k < off + nb) be[k] = 1'b1;
                wd[8*k +: 8] = d[8*(k % nb) +: 8];
            end
        end
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int   ko;
        if (!reset_n) begin
            prev_req = 1'b0;
        end else begin
            if (bus.mem_req) begin
                if (prev_req) begin
                    check("stable_addr", bus.mem_addr, cap_addr);
                    check("stable_wdata", bus.mem_wdata, cap_wdata);
                    check("stable_be", 32'(bus.mem_be), 32'(cap_be));
                end
                cap_addr  = bus.mem_addr;
                cap_wdata = bus.mem_wdata;
                cap_be    = bus.mem_be;
            end else begin
                check("be_zero_noreq", 32'(bus.mem_be), 32'd0);
            end
            prev_req = bus.mem_req;
            if (bus.Done || bus.AddrErr || bus.BusErr) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e  = sb_q.pop_front();
                    ko = bus.Done ? K_DONE : (bus.AddrErr ? K_AERR : K_BERR);
                    check("event_kind", 32'(ko), 32'(e.kind));
                    check("event_onehot", 32'(bus.Done) + 32'(bus.AddrErr) + 32'(bus.BusErr), 32'd1);
                    if (e.kind == K_DONE) begin
                        check("sb_addr", cap_addr, e.addr);
                        check("sb_wdata", cap_wdata, e.wdata);
                        check("sb_be", 32'(cap_be), 32'(e.be));
                    end
                end
            end
        end
    end

    // Drive one store; ack_at is the 1-based REQ cycle carrying mem_ack (0 = never).
    // Returns at the negedge of the IDLE cycle following the store.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input int ack_at);
        logic        ok;
        logic [3:0]  be;
        logic [31:0] wd;
        exp_t        e;
        int          n;
        int          exp_len;
        model(sz, a, d, ok, be, wd);
        bus.StoreSize = sz;
        bus.Addr      = a;
        bus.WDataIn   = d;
        bus.MemWrite  = 1'b1;
        if (!ok) e.kind = K_AERR;
        else if (ack_at >= 1 && ack_at <= TIMEOUT) e.kind = K_DONE;
        else e.kind = K_BERR;
        e.addr  = {a[31:2], 2'b00};
        e.wdata = wd;
        e.be    = be;
        sb_q.push_back(e);
        #1 check("stall_idle", 32'(bus.Stall), 32'(ok));
        @(posedge clk);
        #1 bus.MemWrite = 1'b0;
        if (!ok) begin
            @(negedge clk);
            check("err_no_req", 32'(bus.mem_req), 32'd0);
            check("err_addrerr", 32'(bus.AddrErr), 32'd1);
            check("err_stall", 32'(bus.Stall), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("err_one_cycle", 32'(bus.AddrErr), 32'd0);
        end else begin
            n       = 0;
            exp_len = (e.kind == K_DONE) ? ack_at : TIMEOUT;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!bus.mem_req) break;
                n++;
                check("req_stall", 32'(bus.Stall), 32'd1);
                bus.mem_ack = (n == ack_at);
            end
            bus.mem_ack = 1'b0;
            check("req_len", 32'(n), 32'(exp_len));
            check("done_pulse", 32'(bus.Done), 32'(e.kind == K_DONE));
            check("buserr_pulse", 32'(bus.BusErr), 32'(e.kind == K_BERR));
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.StoreSize = 2'b00;
        bus.Addr      = 32'd0;
        bus.WDataIn   = 32'd0;
        bus.mem_ack   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_be", 32'(bus.mem_be), 32'd0);
        check("rst_flags", {29'd0, bus.Done, bus.AddrErr, bus.BusErr}, 32'd0);
        check("rst_stall", 32'(bus.Stall), 32'd0);
        reset_n = 1'b1;

        do_store(2'b00, 32'h0000_1004, 32'hDEAD_BEEF, 3);
        check("word_addr", cap_addr, 32'h0000_1004);
        check("word_be", 32'(cap_be), 32'hF);
        check("word_wdata", cap_wdata, 32'hDEAD_BEEF);

        do_store(2'b10, 32'h0000_2003, 32'h1234_56A5, 1);
        check("byte_addr", cap_addr, 32'h0000_2000);
        check("byte_be", 32'(cap_be), 32'h8);
        check("byte_wdata", cap_wdata, 32'hA5A5_A5A5);

        do_store(2'b01, 32'h0000_0011, 32'h0000_BEEF, 1);
        do_store(2'b11, 32'h0000_0000, 32'hCAFE_F00D, 1);

        do_store(2'b00, 32'h0000_0100, 32'h1111_2222, 0);
        do_store(2'b00, 32'h0000_0104, 32'h3333_4444, TIMEOUT);

        do_store(2'b01, 32'h0000_0302, 32'hAAAA_1357, 1);
        check("b2b_first_be", 32'(cap_be), 32'hC);
        do_store(2'b01, 32'h0000_0300, 32'hBBBB_2468, 1);
        check("b2b_second_be", 32'(cap_be), 32'h3);

        for (int n = 0; n < 10; n++) begin
            do_store(2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(1, 4)));
        end

        // Reset mid-REQ: store is abandoned with no completion event.
        bus.StoreSize = 2'b01;
        bus.Addr      = 32'h0000_0402;
        bus.WDataIn   = 32'h0000_9ABC;
        bus.MemWrite  = 1'b1;
        @(posedge clk);
        #1 bus.MemWrite = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_req", 32'(bus.mem_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_req", 32'(bus.mem_req), 32'd0);
        check("async_rst_be", 32'(bus.mem_be), 32'd0);
        check("async_rst_addr", bus.mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        check("rst_no_done", {30'd0, bus.Done, bus.BusErr}, 32'd0);
        #1 reset_n = 1'b1;

        do_store(2'b00, 32'h0000_0500, 32'h5A5A_0F0F, 2);
        check("post_rst_addr", cap_addr, 32'h0000_0500);

        repeat (3) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mp32_store_unit.md
MP32_STORE_UNIT -- requirements
Module: mp32_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum cycles mp32_store_unit waits in REQ for mem_ack before it aborts.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset; asynchronous, active-low.
REQ-004 MemWrite  input  1  store request from the MEM stage; sampled only in IDLE.
REQ-005 StoreSize  input  2  store size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-006 Addr  input  32  byte address of the store (the ALUResult of the store instruction).
REQ-007 WDataIn  input  32  store data (register rt value); the store uses the low byte/half/word.
REQ-008 mem_ack  input  1  memory accepted the write this cycle.
REQ-009 mem_req  output  1  write request to data memory.
REQ-010 mem_addr  output  32  word-aligned address: {Addr[31:2],2'b00}.
REQ-011 mem_wdata  output  32  lane-replicated store data.
REQ-012 mem_be  output  4  byte enables; bit k enables byte lane k (little-endian).
REQ-013 Stall  output  1  freeze the pipeline while a store is outstanding.
REQ-014 Done  output  1  one-cycle pulse: store completed.
REQ-015 AddrErr  output  1  one-cycle pulse: misaligned or reserved-size store rejected.
REQ-016 BusErr  output  1  one-cycle pulse: store aborted on timeout.

Function
REQ-017 The FSM SHALL have three states: IDLE, REQ and ERR.
REQ-018 In IDLE with MemWrite=1, the block SHALL check alignment: word needs Addr[1:0]=00, half needs Addr[0]=0, byte is always aligned, and size 11 is always an error.
REQ-019 An aligned store SHALL register mem_addr, mem_wdata and mem_be at the edge, then go to REQ.
REQ-020 A misaligned store SHALL go to ERR; no memory write occurs.
REQ-021 Lane rules: word SHALL give be=1111 and data=WDataIn.
REQ-022 Lane rules: half SHALL give be=0011 (Addr[1]=0) or 1100 (Addr[1]=1), with data={2{WDataIn[15:0]}}.
REQ-023 Lane rules: byte SHALL give be=0001<<Addr[1:0], with data={4{WDataIn[7:0]}}.
REQ-024 In REQ, mem_req SHALL be 1, and mem_addr, mem_wdata and mem_be SHALL stay stable until the cycle mem_ack=1.
REQ-025 In REQ, a 4-bit wait counter SHALL clear on entry and increment each cycle without ack.
REQ-026 In REQ, if mem_ack=1: next state IDLE, and Done=1 for exactly the following cycle.
REQ-027 In REQ, if the counter reaches TIMEOUT without ack: next state IDLE, mem_req drops, and BusErr=1 for exactly the following cycle.
REQ-028 If mem_ack and timeout occur in the same cycle, ack SHALL win: Done pulses and BusErr does not.
REQ-029 ERR SHALL last one cycle with AddrErr=1, then return to IDLE.
REQ-030 Stall SHALL be combinational: 1 when state=REQ, or when state=IDLE and MemWrite=1 and the store is aligned; otherwise 0.
REQ-031 MemWrite SHALL be ignored in REQ and ERR.
REQ-032 In the IDLE cycle carrying the Done pulse, a new MemWrite SHALL be accepted, giving back-to-back stores with no extra gap.
REQ-033 mem_ack SHALL be ignored outside REQ.
REQ-034 mem_req SHALL be 0 in IDLE and ERR.
REQ-035 mem_be SHALL be 0000 whenever mem_req=0.

Reset
REQ-036 reset_n=0 SHALL immediately, without waiting for clk, force: state IDLE, counter 0, and mem_req, mem_addr, mem_wdata, mem_be, Done, AddrErr and BusErr all 0.
REQ-037 Reset during REQ SHALL abandon the store; mem_req SHALL fall during reset, and no Done or BusErr pulse SHALL follow.
REQ-038 After reset_n rises, the first MemWrite SHALL be accepted at the next rising edge.

Verification
REQ-039 Word store: Addr=0x0000_1004, WDataIn=0xDEAD_BEEF, size 00, ack after 2 cycles -> mem_addr=0x0000_1004, be=1111, wdata=0xDEADBEEF; mem_req high 3 cycles; Done 1 cycle later; Stall high throughout.
REQ-040 Byte store: Addr=0x0000_2003, WDataIn=0x1234_56A5, size 10, immediate ack -> mem_addr=0x0000_2000, be=1000, wdata=0xA5A5_A5A5, Done next cycle.
REQ-041 Misaligned half: Addr=0x0000_0011, size 01 -> no mem_req, AddrErr pulses 1 cycle, Stall stays 0.
REQ-042 Reserved size: size 11 at Addr=0x0000_0000 -> AddrErr pulse, no write.
REQ-043 Timeout: aligned word store, mem_ack held 0 -> mem_req high 15 cycles then drops, BusErr 1 cycle; ack arriving exactly on cycle 15 -> Done instead.
REQ-044 Back-to-back plus reset: two half stores with immediate ack (Addr 0x...02, 0x...00) -> be=1100 then 0011 on consecutive requests; then reset_n=0 mid-REQ -> mem_req drops immediately, no Done.
